lcd_ctrl_param: RTL and testbench
=================================

# lcd_ctrl_param

Parametrised image-window controller for the LCD path. It loads a 2^XB × 2^YB pixel image from IROM into an internal buffer and applies commands from the host to a movable 2×2 operation window: shift, max, min, average, rotate, mirror and recentre. On the write command it streams the whole buffer to IRAM. Unlike the fixed 8×8/8-bit generation, it has parametrised geometry and pixel width, a defined command latency, and a done pulse that returns the block to idle so further commands can follow a write.

## Interface
- DW, 8, pixel width in bits
- XB, 3, log2 of image width W (W = 2^XB, XB ≥ 1)
- YB, 3, log2 of image height H (H = 2^YB, YB ≥ 1)
- Derived: AW = XB+YB, N = 2^AW; pixel (x,y) is at address y·W + x.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- cmd  input  4  command code
- cmd_valid  input  1  command strobe
- IROM_Q  input  DW  ROM read data, valid one cycle after address
- IROM_rd  output  1  ROM read enable
- IROM_A  output  AW  ROM address
- IRAM_valid  output  1  RAM write strobe
- IRAM_D  output  DW  RAM write data
- IRAM_A  output  AW  RAM write address
- busy  output  1  block not accepting commands
- done  output  1  one-cycle pulse at end of write-out

## Operation
- States: LOAD, IDLE, EXEC, WRITE.
- Operation point (ox,oy) ranges over ox ∈ 1..W-1 and oy ∈ 1..H-1. Reset and recentre set it to (W/2, H/2).
- Window pixels: UL=(ox-1,oy-1), UR=(ox,oy-1), LL=(ox-1,oy), LR=(ox,oy).
- Commands (cmd code: operation):
  - 0: write out the buffer.
  - 1 / 2 / 3 / 4: shift up / down / left / right, saturating at the range limits (no wrap).
  - 5 / 6: set all four window pixels to their max / min.
  - 7: set all four pixels to the average, floor((UL+UR+LL+LR)/4), computed at DW+2 bits so the sum cannot overflow.
  - 8: counter-clockwise rotate (UL←UR, UR←LR, LR←LL, LL←UL).
  - 9: clockwise rotate (UL←LL, LL←LR, LR←UR, UR←UL).
  - 10: mirror X (swap rows).
  - 11: mirror Y (swap columns).
  - 12: reload; see Configuration.
  - 13: recentre.
  - 14–15: no-op.
- All window updates read the pre-command values; all four writes land in the same cycle.
- LOAD fills the buffer from ROM at address 0..N-1. The operation point is untouched, except after reset.
- WRITE streams buffer addresses 0..N-1 in order. The buffer and operation point are preserved afterwards.

## Timing
- Reset values: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0. State becomes LOAD.
- LOAD:
  - First cycle after release: IROM_rd=1, IROM_A=0.
  - IROM_A increments every cycle up to N-1; IROM_rd drops the cycle after N-1.
  - IROM_Q is captured one cycle after its address.
  - busy goes low N+1 cycles after LOAD entry.
- Handshake:
  - A command is accepted on an edge where cmd_valid=1 and busy=0. cmd is latched and busy=1 from that edge.
  - cmd_valid while busy=1 is ignored; it is not queued.
- EXEC (commands 1–11, 13–15): executes on the next edge, busy=0 on the same edge. busy is high for exactly 1 cycle, so back-to-back commands can be accepted every 2 cycles.
- WRITE:
  - IRAM_valid=1 for exactly N consecutive cycles, with IRAM_A = 0..N-1 and IRAM_D = buffer[IRAM_A].
  - The first beat is the cycle after acceptance.
  - On the edge after the last beat: IRAM_valid=0, done=1 for one cycle, busy=0, state IDLE.
- Reset low in any state, including mid-LOAD or mid-WRITE, forces reset values on that edge and aborts the operation. The buffer contents are don't-care until the reload completes.

## Configuration
- LCD_CTRL_RELOAD_EN defined: cmd 12 enters LOAD exactly as after reset (busy held, N+1 cycles), with the operation point preserved.
- LCD_CTRL_RELOAD_EN undefined: cmd 12 behaves as a no-op EXEC (busy 1 cycle) and no reload logic is built.

## Test plan
- Reset release with DW=8, XB=YB=3 and ROM[i]=i: IROM_A sweeps 0..63, busy falls 65 cycles after release, and write-out gives IRAM_D = IRAM_A for all 64 beats, followed by a single done pulse.
- From the centre (4,4), issue 5 ups then 6 lefts: the point saturates at (1,1). Max then sets addresses 0, 1, 8, 9 to 9.
- Window values UL=255, UR=254, LL=253, LR=1 with average: all four become 190 (763>>2, no overflow). Clockwise rotate on 1,2,3,4 (UL,UR,LL,LR) gives UL=3, UR=1, LL=4, LR=2.
- Hold cmd_valid=1 with cmd=4 for 6 cycles: exactly 3 shifts are accepted, and busy toggles 1,0,1,0,1,0.
- Assert reset low at write beat 20: IRAM_valid=0 and busy=1 on that edge, done never pulses, and LOAD restarts at address 0.
- With LCD_CTRL_RELOAD_EN, change the ROM pattern, then issue cmd 12 followed by write: the output matches the new ROM and the operation point is unchanged. Without the macro, the output matches the old buffer.

Source files
------------

// File: rtl/lcd_ctrl_param_if.sv
// lcd_ctrl_param_if: command handshake plus IROM/IRAM bus of the LCD
// image-window controller.
//   cmd/cmd_valid        host command and strobe
//   busy/done            controller status, done pulses at end of write-out
//   IROM_rd/IROM_A/Q     image ROM read port (Q valid one cycle after A)
//   IRAM_valid/A/D       image RAM write port
// The master modport is the host/memory side, the slave modport is the
// controller.
interface lcd_ctrl_param_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic          done;
    logic          IROM_rd;
    logic [AW-1:0] IROM_A;
    logic [DW-1:0] IROM_Q;
    logic          IRAM_valid;
    logic [AW-1:0] IRAM_A;
    logic [DW-1:0] IRAM_D;

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
    );

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
    );
endinterface

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads a 2^XB x 2^YB image of DW-bit pixels from IROM,
// applies host commands to a movable 2x2 window (shift, max, min, average,
// rotate, mirror, recentre) and streams the buffer to IRAM on command 0.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    lcd_ctrl_param_if.slave (cmd, cmd_valid, busy, done, IROM_*, IRAM_*)
// Optional feature: define LCD_CTRL_RELOAD_EN to make command 12 re-run the
// ROM load (operation point kept); otherwise command 12 is a no-op.
module lcd_ctrl_param #(
    parameter int DW = 8,
    parameter int XB = 3,
    parameter int YB = 3
) (
    input  logic               clk,
    input  logic               reset,
    lcd_ctrl_param_if.slave    bus
);
    localparam int AW = XB + YB;
    localparam int N  = 1 << AW;
    localparam int W  = 1 << XB;
    localparam int H  = 1 << YB;
    localparam logic [AW:0]   LCNT_RD_END = (AW+1)'(N);
    localparam logic [AW:0]   LCNT_DONE   = (AW+1)'(N + 1);
    localparam logic [AW-1:0] ADDR_LAST   = AW'(N - 1);
    localparam logic [XB-1:0] OX_CENTRE   = XB'(W / 2);
    localparam logic [YB-1:0] OY_CENTRE   = YB'(H / 2);

    typedef enum logic [1:0] {LOAD, IDLE, EXEC, WRITE} state_t;
    state_t state, state_n;

    logic [DW-1:0] mem [N];
    logic [XB-1:0] ox, oxm;
    logic [YB-1:0] oy, oym;
    logic [3:0]    cmd_r;
    logic [AW:0]   lcnt;
    logic          rom_rd, rd_d1, rom_active;
    logic [AW-1:0] rom_a, addr_d1;
    logic          ram_valid, done_r;
    logic [AW-1:0] ram_a, wa_n;
    logic [DW-1:0] ram_d;

    logic [AW-1:0] a_ul, a_ur, a_ll, a_lr;
    logic [DW-1:0] v_ul, v_ur, v_ll, v_lr;
    logic [DW-1:0] n_ul, n_ur, n_ll, n_lr;
    logic [DW-1:0] mx_a, mx_b, mx, mn_a, mn_b, mn;
    logic [DW+1:0] sum;
    logic          win_we;

    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_r;
    assign bus.IROM_rd    = rom_rd;
    assign bus.IROM_A     = rom_a;
    assign bus.IRAM_valid = ram_valid;
    assign bus.IRAM_A     = ram_a;
    assign bus.IRAM_D     = ram_d;

    // Pixel (x,y) lives at y*W + x, i.e. {y, x}.
    assign oxm  = ox - XB'(1);
    assign oym  = oy - YB'(1);
    assign a_ul = {oym, oxm};
    assign a_ur = {oym, ox};
    assign a_ll = {oy, oxm};
    assign a_lr = {oy, ox};
    assign v_ul = mem[a_ul];
    assign v_ur = mem[a_ur];
    assign v_ll = mem[a_ll];
    assign v_lr = mem[a_lr];

    // A fetch is issued for LOAD cycles 0..N-1; data arrives two edges later.
    assign rom_active = (state == LOAD) && (lcnt < LCNT_RD_END);
    assign wa_n       = (state == WRITE) ? ram_a + AW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!reset) state <= LOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:  if (lcnt == LCNT_DONE) state_n = IDLE;
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd == 4'd0)       state_n = WRITE;
`ifdef LCD_CTRL_RELOAD_EN
                    else if (bus.cmd == 4'd12) state_n = LOAD;
`endif
                    else                       state_n = EXEC;
                end
            end
            EXEC:  state_n = IDLE;
            WRITE: if (ram_a == ADDR_LAST) state_n = IDLE;
            default: state_n = LOAD;
        endcase
    end

    // Window arithmetic; every result is taken from pre-command pixel values.
    always_comb begin
        mx_a = (v_ul > v_ur) ? v_ul : v_ur;
        mx_b = (v_ll > v_lr) ? v_ll : v_lr;
        mx   = (mx_a > mx_b) ? mx_a : mx_b;
        mn_a = (v_ul < v_ur) ? v_ul : v_ur;
        mn_b = (v_ll < v_lr) ? v_ll : v_lr;
        mn   = (mn_a < mn_b) ? mn_a : mn_b;
        sum  = {2'b00, v_ul} + {2'b00, v_ur} + {2'b00, v_ll} + {2'b00, v_lr};
        n_ul = v_ul;
        n_ur = v_ur;
        n_ll = v_ll;
        n_lr = v_lr;
        win_we = 1'b0;
        if (state == EXEC) begin
            case (cmd_r)
                4'd5:  begin n_ul = mx; n_ur = mx; n_ll = mx; n_lr = mx; win_we = 1'b1; end
                4'd6:  begin n_ul = mn; n_ur = mn; n_ll = mn; n_lr = mn; win_we = 1'b1; end
                4'd7:  begin
                    n_ul = sum[DW+1:2]; n_ur = sum[DW+1:2];
                    n_ll = sum[DW+1:2]; n_lr = sum[DW+1:2];
                    win_we = 1'b1;
                end
                4'd8:  begin n_ul = v_ur; n_ur = v_lr; n_lr = v_ll; n_ll = v_ul; win_we = 1'b1; end
                4'd9:  begin n_ul = v_ll; n_ll = v_lr; n_lr = v_ur; n_ur = v_ul; win_we = 1'b1; end
                4'd10: begin n_ul = v_ll; n_ll = v_ul; n_ur = v_lr; n_lr = v_ur; win_we = 1'b1; end
                4'd11: begin n_ul = v_ur; n_ur = v_ul; n_ll = v_lr; n_lr = v_ll; win_we = 1'b1; end
                default: win_we = 1'b0;
            endcase
        end
    end

    // Image buffer: contents are meaningless until a load completes, so no reset.
    always_ff @(posedge clk) begin
        if (rd_d1) mem[addr_d1] <= bus.IROM_Q;
        if (win_we) begin
            mem[a_ul] <= n_ul;
            mem[a_ur] <= n_ur;
            mem[a_ll] <= n_ll;
            mem[a_lr] <= n_lr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_rd    <= 1'b0;
            rom_a     <= '0;
            rd_d1     <= 1'b0;
            addr_d1   <= '0;
            lcnt      <= '0;
            ram_valid <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            done_r    <= 1'b0;
            cmd_r     <= '0;
            ox        <= OX_CENTRE;
            oy        <= OY_CENTRE;
        end else begin
            rd_d1   <= rom_rd;
            addr_d1 <= rom_a;
            lcnt    <= (state == LOAD) ? lcnt + (AW+1)'(1) : '0;
            rom_rd  <= rom_active;
            if (rom_active) rom_a <= lcnt[AW-1:0];
            if (state == IDLE && bus.cmd_valid) cmd_r <= bus.cmd;
            ram_valid <= (state_n == WRITE);
            if (state_n == WRITE) begin
                ram_a <= wa_n;
                ram_d <= mem[wa_n];
            end
            done_r <= (state == WRITE) && (ram_a == ADDR_LAST);
            if (state == EXEC) begin
                case (cmd_r)
                    4'd1:  if (oy > YB'(1))     oy <= oy - YB'(1);
                    4'd2:  if (oy < YB'(H - 1)) oy <= oy + YB'(1);
                    4'd3:  if (ox > XB'(1))     ox <= ox - XB'(1);
                    4'd4:  if (ox < XB'(W - 1)) ox <= ox + XB'(1);
                    4'd13: begin ox <= OX_CENTRE; oy <= OY_CENTRE; end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed bench for lcd_ctrl_param (DW=8, 8x8 image).
// A behavioural ROM answers one cycle after the address; write-outs are
// captured into cap[] and compared against hand-computed pixel values.
// Honours LCD_CTRL_RELOAD_EN the same way the design does.
module tb_lcd_ctrl_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_ctrl_param_if #(.DW(8), .AW(6)) bus ();
    lcd_ctrl_param #(.DW(8), .XB(3), .YB(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] rom [64];
    logic [7:0] cap [64];
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) bus.IROM_Q <= rom[bus.IROM_A];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_ident;
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 300 && bus.busy !== 1'b0; k++) tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b required 0 within 300 cycles", bus.busy);
        end
    endtask

    task automatic reset_load;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        wait_idle();
    endtask

    task automatic issue(input logic [3:0] c);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
    endtask

    task automatic do_write;
        bit ok;
        int ndone;
        ok = 1'b1;
        ndone = 0;
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int b = 0; b < 64; b++) begin
            if (!(bus.IRAM_valid === 1'b1 && bus.IRAM_A === 6'(b) && bus.busy === 1'b1)) ok = 1'b0;
            if (bus.done !== 1'b0) ndone++;
            cap[b] = bus.IRAM_D;
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_stream: beats not 64 consecutive valid with IRAM_A=0..63 (last A=%0d)", bus.IRAM_A);
        end
        n_checks++;
        if (!(bus.IRAM_valid === 1'b0 && bus.done === 1'b1 && bus.busy === 1'b0 && ndone == 0)) begin
            n_fail++;
            $display("FAIL write_end: valid=%b done=%b busy=%b early_done=%0d required 0,1,0,0",
                     bus.IRAM_valid, bus.done, bus.busy, ndone);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_reset;
        int cyc;
        bit sweep_ok;
        rom_ident();
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.IROM_rd, bus.IROM_A, bus.IRAM_valid, bus.IRAM_D, bus.IRAM_A, bus.busy, bus.done} !==
            {1'b0, 6'd0, 1'b0, 8'd0, 6'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rd=%b romA=%0d valid=%b D=%0d ramA=%0d busy=%b done=%b required 0,0,0,0,0,1,0",
                     bus.IROM_rd, bus.IROM_A, bus.IRAM_valid, bus.IRAM_D, bus.IRAM_A, bus.busy, bus.done);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (!(bus.IROM_rd === 1'b1 && bus.IROM_A === 6'd0)) begin
            n_fail++;
            $display("FAIL first_fetch: rd=%b A=%0d required 1,0", bus.IROM_rd, bus.IROM_A);
        end
        cyc = 0;
        sweep_ok = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i <= 63 && !(bus.IROM_rd === 1'b1 && bus.IROM_A === 6'(i))) sweep_ok = 1'b0;
            if (i == 64 && bus.IROM_rd !== 1'b0) sweep_ok = 1'b0;
            if (bus.busy === 1'b0) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (!sweep_ok) begin
            n_fail++;
            $display("FAIL rom_sweep: IROM_A/IROM_rd did not sweep 0..63 then drop (A=%0d rd=%b)", bus.IROM_A, bus.IROM_rd);
        end
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("FAIL load_latency: busy fell %0d cycles after release, required 65", cyc);
        end
    endtask

    task automatic test_write_ident;
        int bad;
        do_write();
        bad = 0;
        for (int i = 0; i < 64; i++) if (cap[i] !== 8'(i)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write_ident: %0d pixels differ (cap[5]=%0d cap[63]=%0d) required cap[i]=i", bad, cap[5], cap[63]);
        end
    endtask

    task automatic test_shift_sat;
        for (int i = 0; i < 5; i++) issue(4'd1);
        for (int i = 0; i < 6; i++) issue(4'd3);
        issue(4'd5);
        do_write();
        n_checks++;
        if ({cap[0], cap[1], cap[8], cap[9]} !== {8'd9, 8'd9, 8'd9, 8'd9}) begin
            n_fail++;
            $display("FAIL max_at_origin: %0d %0d %0d %0d required 9 9 9 9", cap[0], cap[1], cap[8], cap[9]);
        end
        n_checks++;
        if ({cap[2], cap[10], cap[16]} !== {8'd2, 8'd10, 8'd16}) begin
            n_fail++;
            $display("FAIL max_untouched: %0d %0d %0d required 2 10 16", cap[2], cap[10], cap[16]);
        end
        // recentre, then saturate at the far corner (7,7) and take the min
        issue(4'd13);
        for (int i = 0; i < 5; i++) issue(4'd2);
        for (int i = 0; i < 5; i++) issue(4'd4);
        issue(4'd6);
        do_write();
        n_checks++;
        if ({cap[54], cap[55], cap[62], cap[63], cap[9]} !== {8'd54, 8'd54, 8'd54, 8'd54, 8'd9}) begin
            n_fail++;
            $display("FAIL min_far_corner: %0d %0d %0d %0d (cap9=%0d) required 54 54 54 54 (9)",
                     cap[54], cap[55], cap[62], cap[63], cap[9]);
        end
    endtask

    task automatic test_avg_rotate;
        rom_ident();
        rom[27] = 8'd255; rom[28] = 8'd254; rom[35] = 8'd253; rom[36] = 8'd1;
        reset_load();
        issue(4'd7);
        do_write();
        n_checks++;
        if ({cap[27], cap[28], cap[35], cap[36], cap[26]} !== {8'd190, 8'd190, 8'd190, 8'd190, 8'd26}) begin
            n_fail++;
            $display("FAIL average: %0d %0d %0d %0d (cap26=%0d) required 190 x4 (26)",
                     cap[27], cap[28], cap[35], cap[36], cap[26]);
        end
        rom_ident();
        rom[27] = 8'd1; rom[28] = 8'd2; rom[35] = 8'd3; rom[36] = 8'd4;
        reset_load();
        issue(4'd9);
        do_write();
        n_checks++;
        if ({cap[27], cap[28], cap[35], cap[36]} !== {8'd3, 8'd1, 8'd4, 8'd2}) begin
            n_fail++;
            $display("FAIL rotate_cw: UL=%0d UR=%0d LL=%0d LR=%0d required 3 1 4 2", cap[27], cap[28], cap[35], cap[36]);
        end
        // 3,1,4,2 -> mirror Y 1,3,2,4 -> mirror X 2,4,1,3 -> CCW 4,3,2,1; 14/15 change nothing
        issue(4'd11);
        issue(4'd10);
        issue(4'd8);
        issue(4'd14);
        issue(4'd15);
        do_write();
        n_checks++;
        if ({cap[27], cap[28], cap[35], cap[36], cap[26]} !== {8'd4, 8'd3, 8'd2, 8'd1, 8'd26}) begin
            n_fail++;
            $display("FAIL mirror_ccw: UL=%0d UR=%0d LL=%0d LR=%0d (cap26=%0d) required 4 3 2 1 (26)",
                     cap[27], cap[28], cap[35], cap[36], cap[26]);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] seen;
        rom_ident();
        reset_load();
        bus.cmd = 4'd4;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen[5-i] = bus.busy;
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (seen !== 6'b101010) begin
            n_fail++;
            $display("FAIL busy_pattern: %b required 101010", seen);
        end
        // three shifts right from (4,4) -> (7,4): window 30,31,38,39
        issue(4'd5);
        do_write();
        n_checks++;
        if ({cap[30], cap[31], cap[38], cap[39], cap[29]} !== {8'd39, 8'd39, 8'd39, 8'd39, 8'd29}) begin
            n_fail++;
            $display("FAIL shift_count: %0d %0d %0d %0d (cap29=%0d) required 39 x4 (29)",
                     cap[30], cap[31], cap[38], cap[39], cap[29]);
        end
    endtask

    task automatic test_reset_mid_write;
        int ndone, cyc;
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (!(bus.IRAM_valid === 1'b1 && bus.IRAM_A === 6'd20)) begin
            n_fail++;
            $display("FAIL beat20: valid=%b A=%0d required 1,20", bus.IRAM_valid, bus.IRAM_A);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (!(bus.IRAM_valid === 1'b0 && bus.busy === 1'b1 && bus.done === 1'b0 && bus.IROM_rd === 1'b0)) begin
            n_fail++;
            $display("FAIL abort_write: valid=%b busy=%b done=%b rd=%b required 0,1,0,0",
                     bus.IRAM_valid, bus.busy, bus.done, bus.IROM_rd);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (!(bus.IROM_rd === 1'b1 && bus.IROM_A === 6'd0)) begin
            n_fail++;
            $display("FAIL reload_restart: rd=%b A=%0d required 1,0", bus.IROM_rd, bus.IROM_A);
        end
        ndone = 0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.done !== 1'b0) ndone++;
            if (bus.busy === 1'b0) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (!(ndone == 0 && cyc == 65)) begin
            n_fail++;
            $display("FAIL abort_recovery: done pulses=%0d idle after %0d required 0 and 65", ndone, cyc);
        end
    endtask

    task automatic test_reload;
        int cyc;
        rom_ident();
        reset_load();
        issue(4'd3);
        issue(4'd3);
        for (int i = 0; i < 64; i++) rom[i] = 8'(255 - i);
        bus.cmd = 4'd12;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.busy === 1'b0) begin
                cyc = i;
                break;
            end
        end
        issue(4'd5);
        do_write();
`ifdef LCD_CTRL_RELOAD_EN
        n_checks++;
        if (cyc != 66) begin
            n_fail++;
            $display("FAIL reload_busy: idle %0d cycles after accept-edge+1, required 66", cyc);
        end
        n_checks++;
        if ({cap[25], cap[26], cap[33], cap[34], cap[0], cap[63]} !==
            {8'd230, 8'd230, 8'd230, 8'd230, 8'd255, 8'd192}) begin
            n_fail++;
            $display("FAIL reload_data: %0d %0d %0d %0d %0d %0d required 230 230 230 230 255 192",
                     cap[25], cap[26], cap[33], cap[34], cap[0], cap[63]);
        end
`else
        n_checks++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL noop12_busy: idle %0d cycles later, required 1", cyc);
        end
        n_checks++;
        if ({cap[25], cap[26], cap[33], cap[34], cap[0], cap[63]} !==
            {8'd34, 8'd34, 8'd34, 8'd34, 8'd0, 8'd63}) begin
            n_fail++;
            $display("FAIL noop12_data: %0d %0d %0d %0d %0d %0d required 34 34 34 34 0 63",
                     cap[25], cap[26], cap[33], cap[34], cap[0], cap[63]);
        end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_ident();
        test_shift_sat();
        test_avg_rotate();
        test_back_to_back();
        test_reset_mid_write();
        test_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
